// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with two synchronous
// write ports (WB and late/load), NUM_READ combinational read ports,
// optional same-cycle write-to-read bypass and a per-register pending
// scoreboard for RAW hazard detection in decode.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   writeEnable0/Adr0/Data0        write port 0 (WB)
//   writeEnable1/Adr1/Data1        write port 1 (late/load), wins on conflict
//   readAdr / readData / readBusy  packed read ports, port i at slice i
//   issueEnable / issueAdr         mark a destination register pending
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           writeEnable0,
    input  logic [ADR_WIDTH-1:0]           writeAdr0,
    input  logic [DATA_WIDTH-1:0]          writeData0,
    input  logic                           writeEnable1,
    input  logic [ADR_WIDTH-1:0]           writeAdr1,
    input  logic [DATA_WIDTH-1:0]          writeData1,
    input  logic [NUM_READ*ADR_WIDTH-1:0]  readAdr,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    output logic [NUM_READ-1:0]            readBusy,
    input  logic                           issueEnable,
    input  logic [ADR_WIDTH-1:0]           issueAdr
);

    localparam int DEPTH = 2 ** ADR_WIDTH;
    localparam bit BYP   = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;

    // Effective write/issue strobes: r0 is hardwired and reset blocks all.
    logic wr_ok0;
    logic wr_ok1;
    logic iss_ok;

    assign wr_ok0 = !rst && writeEnable0 && (writeAdr0 != '0);
    assign wr_ok1 = !rst && writeEnable1 && (writeAdr1 != '0);
    assign iss_ok = !rst && issueEnable && (issueAdr != '0);

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        // Port 1 is applied after port 0 so it wins a same-address conflict.
        if (wr_ok0) begin
            regs_d[writeAdr0] = writeData0;
            pend_d[writeAdr0] = 1'b0;
        end
        if (wr_ok1) begin
            regs_d[writeAdr1] = writeData1;
            pend_d[writeAdr1] = 1'b0;
        end
        // Issue applied last: the newer instruction owns the register.
        if (iss_ok) begin
            pend_d[issueAdr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADR_WIDTH-1:0]  ra;
        logic                  hit0;
        logic                  hit1;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra   = readAdr[i*ADR_WIDTH +: ADR_WIDTH];
        assign hit0 = BYP && wr_ok0 && (writeAdr0 == ra);
        assign hit1 = BYP && wr_ok1 && (writeAdr1 == ra);

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (!rst && (ra != '0)) begin
                if (hit1) begin
                    rd = writeData1;
                end else if (hit0) begin
                    rd = writeData0;
                end else begin
                    rd = regs_q[ra];
                end
                // Forwarded data is final, so the register is not busy.
                rb = pend_q[ra] && !(hit0 || hit1);
            end
        end

        assign readData[i*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign readBusy[i] = rb;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the 5-stage RISC-V core, successor to the single-write/two-read file. It provides NUM_READ asynchronous read ports and two synchronous write ports: WB, plus a late port for load/long-latency results. It adds optional same-cycle write-to-read bypass, asynchronous clear of all registers, and a per-register pending scoreboard. Decode uses the scoreboard to detect RAW hazards against in-flight instructions.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADR_WIDTH, 5, address width; depth = 2**ADR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- writeEnable0  input  1  write port 0 (WB) enable
- writeAdr0  input  ADR_WIDTH  write port 0 address
- writeData0  input  DATA_WIDTH  write port 0 data
- writeEnable1  input  1  write port 1 (late/load) enable
- writeAdr1  input  ADR_WIDTH  write port 1 address
- writeData1  input  DATA_WIDTH  write port 1 data
- readAdr  input  NUM_READ*ADR_WIDTH  packed read addresses; port i = bits [i*ADR_WIDTH +: ADR_WIDTH]
- readData  output  NUM_READ*DATA_WIDTH  packed read data, same packing
- readBusy  output  NUM_READ  pending flag of each read port's register
- issueEnable  input  1  mark issueAdr as pending (instruction with destination issued)
- issueAdr  input  ADR_WIDTH  destination register of issued instruction

## Operation
- Register 0 is hardwired:
  - it always reads 0 and is never busy;
  - writes and issues to address 0 are ignored.
- Writes are synchronous. If both ports are enabled for the same nonzero address, port 1 wins and port 0's write is dropped. Different addresses are both written.
- Reads are combinational, per port, independent.
  - BYPASS=0: readData = stored value.
  - BYPASS=1: if a write port is enabled for the read address this cycle, readData = that port's writeData, with port 1 having priority. Otherwise readData = stored value.
- Scoreboard: one pending bit per register, updated on the rising edge.
  - Cleared by a write from either port to that address.
  - Set by issueEnable to that address.
  - Set and clear to the same address in the same cycle: set wins, because the newer instruction owns the register.
- readBusy[i] = pending bit of readAdr port i. With BYPASS=1, readBusy[i] is forced 0 in any cycle where a write to that address is present, since the data is being forwarded.
- Writes to a non-pending register are legal and do not alter the scoreboard.

## Timing
- Reset: while rst is high, all registers = 0 and all pending bits = 0, taking effect immediately without waiting for a clock edge.
  - readData = 0 and readBusy = 0 on every port while rst is high.
  - Bypass is gated off during reset.
  - Writes and issues during reset are ignored.
- Reset deassertion mid-operation: the first rising edge with rst low performs normal updates.
- Write latency: data is stored at edge N. With BYPASS=0 it is readable from the combinational read path after edge N. With BYPASS=1 it is visible in the same cycle.
- Issue latency: readBusy asserts the cycle after issueEnable's edge. It does not reflect an issue in the same cycle.
- Scoreboard clear latency: the pending bit drops after the write edge. With BYPASS=1, readBusy is already 0 during the write cycle.
- No handshake or back-pressure; every enable is accepted every cycle.
- Combinational paths: readAdr, writeAdr, writeEnable and writeData feed readData and readBusy. rst also gates these paths.

## Test plan
- Reset: preload r5 = 0xDEADBEEF and mark r5 pending, then assert rst asynchronously between edges -> readData for r5 = 0 and readBusy = 0 before the next edge. After release, all reads return 0.
- x0: write 0xFFFFFFFF to r0 via both ports and issue r0 -> reads of r0 return 0 and readBusy = 0 on every port.
- Dual-write conflict: port 0 writes r7 = 0x11 and port 1 writes r7 = 0x22 in the same cycle -> r7 reads 0x22 afterwards.
  - Same cycle with different addresses: r8 = 0x33, r9 = 0x44 -> both are stored.
- Bypass: BYPASS=1, port 0 writes r3 = 0xA5A5 while read port 1 addresses r3 -> readData = 0xA5A5 in that cycle.
  - Repeat with BYPASS=0 -> the old value in that cycle and 0xA5A5 the next cycle.
- Scoreboard: issue r10 -> readBusy = 1 from the next cycle. Write r10 via port 1 three cycles later -> busy drops: in the write cycle with BYPASS=1, or after the edge with BYPASS=0.
- Set/clear collision: with r12 pending, write r12 and issue r12 in the same cycle -> r12 is still pending afterwards, with the new data stored. Run NUM_READ=4 with all ports addressing distinct registers -> each port returns the correct data and busy flag.
